mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 65 ++++++
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size codes (funct3),
// base byte-enable patterns, the FSM state type, the captured bus request
// and small helpers for legality, byte enables and store lane replication.
package mem_pkg;

  localparam logic [2:0] MP_LB  = 3'b000;
  localparam logic [2:0] MP_LH  = 3'b001;
  localparam logic [2:0] MP_LW  = 3'b010;
  localparam logic [2:0] MP_LBU = 3'b100;
  localparam logic [2:0] MP_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } bus_req_t;

  // Code must be legal for the direction and the address naturally aligned.
  function automatic logic access_ok(input logic is_load, input logic [2:0] code,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (code)
      MP_LB:   ok = 1'b1;
      MP_LH:   ok = ~off[0];
      MP_LW:   ok = (off == 2'b00);
      MP_LBU:  ok = is_load;
      MP_LHU:  ok = is_load & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] base_be(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      2'b00:   be = BE_BYTE;
      2'b01:   be = BE_HALF;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicate store data across all byte lanes so any enabled lane carries it.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the read word down by the byte offset and
// truncates plus sign/zero extends according to the access code.
// Ports: rdata_i read word, off_i byte offset, code_i funct3, data_o result.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  code_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (code_i)
      MP_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      MP_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      MP_LBU:  data_o = {24'b0, shifted[7:0]};
      MP_LHU:  data_o = {16'b0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage. Non-memory ops and branches resolve in one cycle;
// legal loads/stores run a data-bus transaction in BUS state until dmem_ack
// or ACK_TIMEOUT cycles elapse. Misaligned/illegal accesses pulse misalign.
// Ports: CLK/RST_N; execute-stage inputs (alu_res, PC_i, branch_offset_i,
// store_value_i, alu_wb_en, load_flag_i, mem_en_i, branch_flag_i, rd_i,
// mem_para_i); data bus (dmem_*); write-back (wb_*); branch redirect
// (branch_take, branch_target); stall, misalign, bus_fault.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] alu_res,
  input  logic [31:0] PC_i,
  input  logic [31:0] branch_offset_i,
  input  logic [31:0] store_value_i,
  input  logic        alu_wb_en,
  input  logic        load_flag_i,
  input  logic        mem_en_i,
  input  logic        branch_flag_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  mem_para_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        branch_take,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        misalign,
  output logic        bus_fault
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_req_t          req_q, req_d;
  logic              ld_q, ld_d;
  logic              wbreq_q, wbreq_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        code_q, code_d;
  logic [1:0]        off_q, off_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              br_take_q, br_take_d;
  logic [31:0]       br_tgt_q, br_tgt_d;
  logic              mis_q, mis_d;
  logic              fault_q, fault_d;
  logic [31:0]       ld_data;
  logic              in_bus;

  mem_load_align u_align (
    .rdata_i (dmem_rdata),
    .off_i   (off_q),
    .code_i  (code_q),
    .data_o  (ld_data)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    ld_d      = ld_q;
    wbreq_d   = wbreq_q;
    rd_d      = rd_q;
    code_d    = code_q;
    off_d     = off_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    br_take_d = 1'b0;
    br_tgt_d  = br_tgt_q;
    mis_d     = 1'b0;
    fault_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_en_i) begin
          if (!access_ok(load_flag_i, mem_para_i, alu_res[1:0])) begin
            mis_d = 1'b1;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            req_d.addr  = {alu_res[31:2], 2'b00};
            req_d.be    = 4'(base_be(mem_para_i[1:0]) << alu_res[1:0]);
            req_d.wdata = lane_data(mem_para_i[1:0], store_value_i);
            req_d.we    = ~load_flag_i;
            ld_d        = load_flag_i;
            wbreq_d     = alu_wb_en;
            rd_d        = rd_i;
            code_d      = mem_para_i;
            off_d       = alu_res[1:0];
          end
        end else if (branch_flag_i) begin
          br_take_d = alu_res[0];
          br_tgt_d  = PC_i + branch_offset_i;
        end else begin
          wb_en_d   = alu_wb_en && (rd_i != 5'd0);
          wb_rd_d   = rd_i;
          wb_data_d = alu_res;
        end
      end
      ST_BUS: begin
        if (dmem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (ld_q) begin
            wb_en_d   = wbreq_q && (rd_q != 5'd0);
            wb_rd_d   = rd_q;
            wb_data_d = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      ld_q      <= 1'b0;
      wbreq_q   <= 1'b0;
      rd_q      <= 5'd0;
      code_q    <= 3'd0;
      off_q     <= 2'd0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      br_take_q <= 1'b0;
      br_tgt_q  <= 32'd0;
      mis_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      ld_q      <= ld_d;
      wbreq_q   <= wbreq_d;
      rd_q      <= rd_d;
      code_q    <= code_d;
      off_q     <= off_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      br_take_q <= br_take_d;
      br_tgt_q  <= br_tgt_d;
      mis_q     <= mis_d;
      fault_q   <= fault_d;
    end
  end

  // Bus controls follow the state register so reset drops them at once.
  assign in_bus        = (state_q == ST_BUS);
  assign stall         = in_bus;
  assign dmem_req      = in_bus;
  assign dmem_we       = in_bus & req_q.we;
  assign dmem_be       = in_bus ? req_q.be : 4'b0000;
  assign dmem_addr     = req_q.addr;
  assign dmem_wdata    = req_q.wdata;
  assign wb_en         = wb_en_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign branch_take   = br_take_q;
  assign branch_target = br_tgt_q;
  assign misalign      = mis_q;
  assign bus_fault     = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// op stream checked against an arithmetic reference model.
module tb_mem_stage;

  logic        CLK, RST_N;
  logic [31:0] alu_res, PC_i, branch_offset_i, store_value_i;
  logic        alu_wb_en, load_flag_i, mem_en_i, branch_flag_i;
  logic [4:0]  rd_i;
  logic [2:0]  mem_para_i;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_en, branch_take, stall, misalign, bus_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, branch_target;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .alu_res(alu_res), .PC_i(PC_i),
    .branch_offset_i(branch_offset_i), .store_value_i(store_value_i),
    .alu_wb_en(alu_wb_en), .load_flag_i(load_flag_i), .mem_en_i(mem_en_i),
    .branch_flag_i(branch_flag_i), .rd_i(rd_i), .mem_para_i(mem_para_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .branch_take(branch_take), .branch_target(branch_target), .stall(stall),
    .misalign(misalign), .bus_fault(bus_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] code);
    return 1 << code[1:0];
  endfunction

  function automatic logic m_legal(input logic ld, input logic [2:0] code, input logic [31:0] addr);
    logic ok;
    if (ld) ok = (code inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    ok = (code inside {3'd0, 3'd1, 3'd2});
    return ok && ((int'(addr[1:0]) % m_size(code)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] code, input logic [31:0] addr);
    int v;
    v = ((1 << m_size(code)) - 1) << int'(addr[1:0]);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] code, input logic [31:0] d);
    logic [31:0] w;
    int size;
    size = m_size(code);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] code, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [63:0] v, mask;
    int size;
    size = m_size(code);
    v    = 64'(rdata) >> (8 * int'(addr[1:0]));
    mask = (64'd1 << (8 * size)) - 64'd1;
    v    = v & mask;
    if (!code[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    mem_en_i = 1'b0; branch_flag_i = 1'b0; alu_wb_en = 1'b0; dmem_ack = 1'b0;
    load_flag_i = 1'($urandom); alu_res = $urandom; rd_i = 5'($urandom);
    mem_para_i = 3'($urandom); PC_i = $urandom; branch_offset_i = $urandom;
    store_value_i = $urandom; dmem_rdata = $urandom;
  endtask

  task automatic scramble();
    mem_en_i = 1'($urandom); branch_flag_i = 1'($urandom); alu_wb_en = 1'($urandom);
    load_flag_i = 1'($urandom); alu_res = $urandom; rd_i = 5'($urandom);
    mem_para_i = 3'($urandom); store_value_i = $urandom; dmem_rdata = $urandom;
  endtask

  task automatic run_alu(input logic [31:0] res, input logic [4:0] rd, input logic wbe, input string tag);
    logic exp_en;
    set_idle();
    alu_res = res; rd_i = rd; alu_wb_en = wbe; dmem_ack = 1'($urandom);
    exp_en = wbe && (rd != 5'd0);
    step();
    n_checks++;
    if ({wb_en, wb_rd, wb_data, stall, dmem_req, branch_take, misalign, bus_fault} !==
        {exp_en, rd, res, 5'b00000}) begin
      n_fail++;
      $display("FAIL %s: got en=%b rd=%0d data=%h st=%b req=%b want en=%b rd=%0d data=%h st=0 req=0",
               tag, wb_en, wb_rd, wb_data, stall, dmem_req, exp_en, rd, res);
    end
    set_idle();
  endtask

  task automatic run_branch(input logic [31:0] res, input logic [31:0] pc, input logic [31:0] off,
                            input string tag);
    set_idle();
    alu_res = res; PC_i = pc; branch_offset_i = off; branch_flag_i = 1'b1; alu_wb_en = 1'b1;
    step();
    n_checks++;
    if ({branch_take, branch_target, wb_en, stall, dmem_req} !== {res[0], pc + off, 3'b000}) begin
      n_fail++;
      $display("FAIL %s: got take=%b tgt=%h wb=%b st=%b want take=%b tgt=%h wb=0 st=0",
               tag, branch_take, branch_target, wb_en, stall, res[0], pc + off);
    end
    set_idle();
    step();
    n_checks++;
    if (branch_take !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: got take=%b want 0", tag, branch_take);
    end
  endtask

  task automatic run_mem(input logic ld, input logic [2:0] code, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int ack_dly,
                         input logic [4:0] rd, input logic wbe, input string tag,
                         output logic [31:0] o_addr, output logic [3:0] o_be,
                         output logic [31:0] o_wdata, output logic o_we,
                         output logic [31:0] o_data, output int o_stall, output logic o_mis);
    logic legal, exp_wb;
    legal = m_legal(ld, code, addr);
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0; o_stall = 0;
    set_idle();
    alu_res = addr; store_value_i = sdata; load_flag_i = ld; mem_en_i = 1'b1;
    rd_i = rd; mem_para_i = code; alu_wb_en = wbe;
    step();
    o_mis = misalign;
    if (!legal) begin
      n_checks++;
      if ({misalign, dmem_req, stall, wb_en, bus_fault} !== 5'b10000) begin
        n_fail++;
        $display("FAIL %s_illegal: got mis/req/st/wb/flt=%b want 10000", tag,
                 {misalign, dmem_req, stall, wb_en, bus_fault});
      end
      set_idle();
      step();
      n_checks++;
      if ({misalign, dmem_req, stall} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_illegal_after: got mis/req/st=%b want 000", tag, {misalign, dmem_req, stall});
      end
      o_data = wb_data;
      return;
    end
    scramble();
    for (int c = 1; c <= ack_dly; c++) begin
      n_checks++;
      if ({dmem_req, stall, wb_en, misalign, bus_fault, branch_take} !== 6'b110000) begin
        n_fail++;
        $display("FAIL %s_bus_ctl cyc %0d: got %b want 110000", tag, c,
                 {dmem_req, stall, wb_en, misalign, bus_fault, branch_take});
      end
      n_checks++;
      if ({dmem_addr, dmem_be, dmem_we} !== {addr & ~32'h3, m_be(code, addr), ~ld}) begin
        n_fail++;
        $display("FAIL %s_bus_addr cyc %0d: got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                 tag, c, dmem_addr, dmem_be, dmem_we, addr & ~32'h3, m_be(code, addr), ~ld);
      end
      if (!ld) begin
        n_checks++;
        if (dmem_wdata !== m_wdata(code, sdata)) begin
          n_fail++;
          $display("FAIL %s_wdata: got %h want %h", tag, dmem_wdata, m_wdata(code, sdata));
        end
      end
      if (c == 1) begin o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we; end
      if (stall === 1'b1) o_stall++;
      dmem_ack = (c == ack_dly);
      if (c == ack_dly) dmem_rdata = rdata;
      step();
    end
    set_idle();
    exp_wb = ld && wbe && (rd != 5'd0);
    n_checks++;
    if ({stall, dmem_req, wb_en, bus_fault} !== {2'b00, exp_wb, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_done: got st/req/wb/flt=%b want %b", tag,
               {stall, dmem_req, wb_en, bus_fault}, {2'b00, exp_wb, 1'b0});
    end
    if (exp_wb) begin
      n_checks++;
      if ({wb_rd, wb_data} !== {rd, m_load(code, addr, rdata)}) begin
        n_fail++;
        $display("FAIL %s_load: got rd=%0d data=%h want rd=%0d data=%h", tag, wb_rd, wb_data,
                 rd, m_load(code, addr, rdata));
      end
    end
    o_data = wb_data;
    step();
    n_checks++;
    if (wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_wb_pulse: got %b want 0", tag, wb_en);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_en, wb_rd, wb_data, branch_take,
         branch_target, stall, misalign, bus_fault} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b st=%b wb=%b addr=%h data=%h tgt=%h want all 0",
               dmem_req, stall, wb_en, dmem_addr, wb_data, branch_target);
    end
    #3 RST_N = 1'b1;
  endtask

  task automatic test_alu();
    run_alu(32'h0000_0005, 5'd3, 1'b1, "add");
    run_alu(32'hDEAD_BEEF, 5'd0, 1'b1, "rd0");
    run_alu(32'h1234_5678, 5'd9, 1'b0, "nowb");
  endtask

  task automatic test_branch();
    run_branch(32'h1, 32'h100, 32'hFFFF_FFF0, "beq_taken");
    run_branch(32'h0, 32'hFFFF_FFF8, 32'h10, "bne_not_taken");
  endtask

  task automatic test_load();
    logic [31:0] a, wd, d; logic [3:0] be; logic we, mis; int st;
    run_mem(1'b1, 3'b000, 32'h1003, 32'h0, 32'h80AA_BBCC, 1, 5'd5, 1'b1, "lb", a, be, wd, we, d, st, mis);
    n_checks++;
    if ({a, be, d} !== {32'h1000, 4'b1000, 32'hFFFF_FF80}) begin
      n_fail++;
      $display("FAIL lb_const: got addr=%h be=%b data=%h want 1000 1000 ffffff80", a, be, d);
    end
    run_mem(1'b1, 3'b100, 32'h1003, 32'h0, 32'h80AA_BBCC, 1, 5'd6, 1'b1, "lbu", a, be, wd, we, d, st, mis);
    n_checks++;
    if (d !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu_const: got %h want 00000080", d);
    end
  endtask

  task automatic test_store();
    logic [31:0] a, wd, d; logic [3:0] be; logic we, mis; int st;
    run_mem(1'b0, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 5'd4, 1'b1, "sh", a, be, wd, we, d, st, mis);
    n_checks++;
    if ({be, wd, we} !== {4'b1100, 32'hABCD_ABCD, 1'b1} || st !== 3) begin
      n_fail++;
      $display("FAIL sh_const: got be=%b wdata=%h we=%b stall_cycles=%0d want 1100 abcdabcd 1 3",
               be, wd, we, st);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] a, wd, d; logic [3:0] be; logic we, mis; int st;
    run_mem(1'b1, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1, 5'd2, 1'b1, "lw_mis", a, be, wd, we, d, st, mis);
    n_checks++;
    if (mis !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_mis_const: got misalign=%b want 1", mis);
    end
    run_mem(1'b1, 3'b101, 32'h0000_0011, 32'h0, 32'h0, 1, 5'd2, 1'b1, "lhu_mis", a, be, wd, we, d, st, mis);
    run_mem(1'b0, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 1, 5'd2, 1'b1, "st_badcode", a, be, wd, we, d, st, mis);
  endtask

  task automatic test_timeout();
    int req_cycles;
    set_idle();
    alu_res = 32'h0000_0100; load_flag_i = 1'b1; mem_en_i = 1'b1; mem_para_i = 3'b010;
    rd_i = 5'd7; alu_wb_en = 1'b1;
    step();
    scramble();
    dmem_ack = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req !== 1'b1) break;
      req_cycles++;
      step();
    end
    set_idle();
    n_checks++;
    if (req_cycles !== 16) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d req cycles want 16", req_cycles);
    end
    n_checks++;
    if ({dmem_req, stall, bus_fault, wb_en} !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_fault: got req/st/flt/wb=%b want 0010", {dmem_req, stall, bus_fault, wb_en});
    end
    step();
    n_checks++;
    if ({bus_fault, wb_en, stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_pulse: got flt/wb/st=%b want 000", {bus_fault, wb_en, stall});
    end
  endtask

  task automatic test_reset_in_bus();
    set_idle();
    alu_res = 32'h0000_0200; load_flag_i = 1'b1; mem_en_i = 1'b1; mem_para_i = 3'b010;
    rd_i = 5'd8; alu_wb_en = 1'b1;
    step();
    set_idle();
    step();
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, stall, wb_en, bus_fault} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_bus: got req/st/wb/flt=%b want 0000", {dmem_req, stall, wb_en, bus_fault});
    end
    #1 RST_N = 1'b1;
    dmem_ack = 1'b1;
    run_alu(32'h0000_0042, 5'd3, 1'b1, "add_after_rst");
    n_checks++;
    if ({bus_fault, misalign, stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_bus_after: got flt/mis/st=%b want 000", {bus_fault, misalign, stall});
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, d; logic [3:0] be; logic we, mis; int st;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: run_alu($urandom, 5'($urandom), 1'($urandom), "rnd_alu");
        1: run_branch($urandom, $urandom, $urandom, "rnd_br");
        default: run_mem(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                         int'($urandom_range(1, 4)), 5'($urandom), 1'($urandom), "rnd_mem",
                         a, be, wd, we, d, st, mis);
      endcase
    end
  endtask

  initial begin
    RST_N = 1'b0;
    set_idle();
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_in_bus();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
